mod_uart_rx_cfg: RTL and testbench

Parametrised UART receiver, next generation of the fixed 8N1 receiver. Adds configurable data width, optional parity, 1 or 2 stop bits, and an input synchroniser with false-start rejection. Also adds a valid/ready output handshake with parity, framing and overrun error reporting. It sits between the asynchronous serial pin and the byte-consuming logic (FIFO or command parser) in the UART subsystem.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/mod_uart_rx_cfg.sv | 159 +++++++++++++++
 tb/tb_mod_uart_rx_cfg.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM state encoding and parameter checks.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  function automatic bit uart_cfg_ok(input int clks_per_bit, input int data_bits,
                                     input int parity, input int stop_bits);
    return (clks_per_bit >= 4) && ((clks_per_bit % 2) == 0) &&
           (data_bits >= 5) && (data_bits <= 9) &&
           (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
           (stop_bits >= 1) && (stop_bits <= 2);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial pin plus falling-edge detect on the synchronised line.
// Latency: rx_s lags the pin by 2 cycles; fall pulses the cycle rx_s first reads low.
// Backpressure: none.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic       meta_q;
  logic       rx_d_q;
  logic [2:0] fill_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_d_q <= 1'b1;
      fill_q <= '0;
    end else begin
      meta_q <= rx;
      rx_s   <= meta_q;
      rx_d_q <= rx_s;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  // Edges are only trusted once the whole chain holds pin samples, so a line
  // that is already low when reset drops never looks like a start bit.
  assign fall = fill_q[2] & rx_d_q & ~rx_s;

endmodule

// File: rtl/mod_uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop bits).
// Latency: rx_valid rises CLKS_PER_BIT/2 + N*CLKS_PER_BIT + 1 cycles after the start edge is seen.
// Backpressure: the line cannot be stalled; an unaccepted frame is overwritten and flagged overrun.
module mod_uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 128,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  if (!uart_cfg_ok(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS)) begin : g_cfg_check
    $error("mod_uart_rx_cfg: unsupported parameter combination");
  end

  localparam int               CNT_W         = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID       = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       IDX_STOP_LAST = 4'(STOP_BITS - 1);

  uart_state_t          state_q;
  uart_state_t          state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic                 stop_bad_q;
  logic                 rx_s;
  logic                 fall;
  logic                 sample;
  logic                 load;
  logic                 par_err_w;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The start bit is sampled half a bit in; every later sample is a full bit apart.
  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        sample = (cnt_q == CNT_MID);
        if (sample) state_d = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        sample = (cnt_q == CNT_LAST);
        if (sample && (idx_q == IDX_DATA_LAST))
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        sample = (cnt_q == CNT_LAST);
        if (sample) state_d = ST_STOP;
      end
      ST_STOP: begin
        sample = (cnt_q == CNT_LAST);
        if (sample && (idx_q == IDX_STOP_LAST)) begin
          state_d = ST_IDLE;
          load    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    par_err_w = 1'b0;
    if (PARITY == PAR_ODD) begin
      par_err_w = ~(^{shift_q, par_bit_q});
    end else if (PARITY == PAR_EVEN) begin
      par_err_w = ^{shift_q, par_bit_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) || sample) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (state_d != state_q) begin
        idx_q <= '0;
      end else if (sample) begin
        idx_q <= idx_q + 4'd1;
      end

      if ((state_q == ST_DATA) && sample) begin
        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
      end

      if ((state_q == ST_PARITY) && sample) begin
        par_bit_q <= rx_s;
      end

      if (state_q == ST_START) begin
        stop_bad_q <= 1'b0;
      end else if ((state_q == ST_STOP) && sample && !rx_s) begin
        stop_bad_q <= 1'b1;
      end
    end
  end

  // Output holding register; the final stop sample is folded in directly at load time.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (load) begin
      rx_data     <= shift_q;
      rx_valid    <= 1'b1;
      parity_err  <= par_err_w;
      frame_err   <= stop_bad_q | ~rx_s;
      overrun_err <= rx_valid & ~rx_ready;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_uart_rx_cfg.sv
// Directed bench for mod_uart_rx_cfg: three instances (8N1, 8E1, 8N2) at 128 clocks per bit.
module tb_mod_uart_rx_cfg;
  import uart_pkg::*;

  localparam int CPB = 128;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx   [3];
  logic       rdy  [3];
  logic [7:0] data [3];
  logic       vld  [3];
  logic       pe   [3];
  logic       fe   [3];
  logic       oe   [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int         vld_cnt   [3];
  int         rise_cyc  [3];
  logic [7:0] cap_data  [3];
  logic [2:0] cap_flags [3];
  logic       vld_prev  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .rx(rx[0]), .rx_data(data[0]), .rx_valid(vld[0]),
    .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun_err(oe[0]));

  mod_uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .rx(rx[1]), .rx_data(data[1]), .rx_valid(vld[1]),
    .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun_err(oe[1]));

  mod_uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .reset(reset), .rx(rx[2]), .rx_data(data[2]), .rx_valid(vld[2]),
    .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun_err(oe[2]));

  // Records the cycle, data and flags of each rising rx_valid, and counts valid cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] === 1'b1) begin
        vld_cnt[i]++;
        if (vld_prev[i] !== 1'b1) begin
          rise_cyc[i]  = cyc;
          cap_data[i]  = data[i];
          cap_flags[i] = {pe[i], fe[i], oe[i]};
        end
      end
      vld_prev[i] = vld[i];
    end
  end

  // Bits go out LSB first, each held CPB cycles; the line returns idle afterwards.
  task automatic send_bits(input int ch, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx[ch] = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx[ch] = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rx[i]  = 1'b1;
      rdy[i] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({data[i], vld[i], pe[i], fe[i], oe[i]} !== 12'h000) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: got data=%h vld=%b pe=%b fe=%b oe=%b want all 0",
                 i, data[i], vld[i], pe[i], fe[i], oe[i]);
      end
    end
    n_cmp++;
    if (dut_a.state_q !== ST_IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want %0d", dut_a.state_q, ST_IDLE);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_8n1();
    int t0;
    vld_cnt[0] = 0;
    t0 = cyc;
    send_bits(0, {6'd0, 1'b1, 8'hB5, 1'b0}, 10);
    repeat (50) @(negedge clk);
    n_cmp++;
    if (rise_cyc[0] !== t0 + 1219) begin
      n_bad++;
      $display("FAIL 8n1_latency: got cycle %0d want %0d", rise_cyc[0], t0 + 1219);
    end
    n_cmp++;
    if (vld_cnt[0] !== 1) begin
      n_bad++;
      $display("FAIL 8n1_valid_cycles: got %0d want 1", vld_cnt[0]);
    end
    n_cmp++;
    if (cap_data[0] !== 8'hB5) begin
      n_bad++;
      $display("FAIL 8n1_data: got %h want b5", cap_data[0]);
    end
    n_cmp++;
    if (cap_flags[0] !== 3'b000) begin
      n_bad++;
      $display("FAIL 8n1_flags: got %b want 000", cap_flags[0]);
    end
  endtask

  task automatic test_parity();
    send_bits(1, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (50) @(negedge clk);
    n_cmp++;
    if (cap_data[1] !== 8'h07) begin
      n_bad++;
      $display("FAIL par_bad_data: got %h want 07", cap_data[1]);
    end
    n_cmp++;
    if (cap_flags[1] !== 3'b100) begin
      n_bad++;
      $display("FAIL par_bad_flags: got pe,fe,oe=%b want 100", cap_flags[1]);
    end
    send_bits(1, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (50) @(negedge clk);
    n_cmp++;
    if (cap_data[1] !== 8'h07) begin
      n_bad++;
      $display("FAIL par_good_data: got %h want 07", cap_data[1]);
    end
    n_cmp++;
    if (cap_flags[1] !== 3'b000) begin
      n_bad++;
      $display("FAIL par_good_flags: got pe,fe,oe=%b want 000", cap_flags[1]);
    end
  endtask

  task automatic test_false_start();
    int t0;
    vld_cnt[0] = 0;
    t0 = cyc;
    rx[0] = 1'b0;
    repeat (16) @(negedge clk);
    rx[0] = 1'b1;
    while (cyc < t0 + 10) @(negedge clk);
    n_cmp++;
    if (dut_a.state_q !== ST_START) begin
      n_bad++;
      $display("FAIL glitch_seen: got state %0d want %0d", dut_a.state_q, ST_START);
    end
    while (cyc < t0 + 67) @(negedge clk);
    n_cmp++;
    if (dut_a.state_q !== ST_IDLE) begin
      n_bad++;
      $display("FAIL glitch_idle: got state %0d want %0d", dut_a.state_q, ST_IDLE);
    end
    repeat (1300) @(negedge clk);
    n_cmp++;
    if (vld_cnt[0] !== 0) begin
      n_bad++;
      $display("FAIL glitch_no_frame: got %0d valid cycles want 0", vld_cnt[0]);
    end
  endtask

  task automatic test_two_stop();
    send_bits(2, {5'd0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    repeat (50) @(negedge clk);
    n_cmp++;
    if (cap_data[2] !== 8'h3C) begin
      n_bad++;
      $display("FAIL stop2_bad_data: got %h want 3c", cap_data[2]);
    end
    n_cmp++;
    if (cap_flags[2] !== 3'b010) begin
      n_bad++;
      $display("FAIL stop2_bad_flags: got pe,fe,oe=%b want 010", cap_flags[2]);
    end
    send_bits(2, {5'd0, 1'b1, 1'b1, 8'hC3, 1'b0}, 11);
    repeat (50) @(negedge clk);
    n_cmp++;
    if ({cap_data[2], cap_flags[2]} !== {8'hC3, 3'b000}) begin
      n_bad++;
      $display("FAIL stop2_good: got data=%h flags=%b want c3 000", cap_data[2], cap_flags[2]);
    end
  endtask

  task automatic test_back_to_back();
    rdy[0] = 1'b0;
    send_bits(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
    send_bits(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({cap_data[0], cap_flags[0]} !== {8'h11, 3'b000}) begin
      n_bad++;
      $display("FAIL b2b_first: got data=%h flags=%b want 11 000", cap_data[0], cap_flags[0]);
    end
    n_cmp++;
    if (data[0] !== 8'h22) begin
      n_bad++;
      $display("FAIL b2b_data: got %h want 22", data[0]);
    end
    n_cmp++;
    if ({vld[0], oe[0], fe[0], pe[0]} !== 4'b1100) begin
      n_bad++;
      $display("FAIL b2b_overrun: got vld=%b oe=%b fe=%b pe=%b want 1 1 0 0",
               vld[0], oe[0], fe[0], pe[0]);
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    n_cmp++;
    if (vld[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept: got vld=%b want 0", vld[0]);
    end
    repeat (5) @(negedge clk);
    rdy[0] = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    send_bits(0, {11'd0, 4'hA, 1'b0}, 5);
    rx[0] = 1'b0;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({data[0], vld[0], pe[0], fe[0], oe[0]} !== 12'h000) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got data=%h vld=%b pe=%b fe=%b oe=%b want all 0",
               data[0], vld[0], pe[0], fe[0], oe[0]);
    end
    n_cmp++;
    if (data[1] !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_mid_other: got %h want 00", data[1]);
    end
    vld_cnt[0] = 0;
    repeat (1500) @(negedge clk);
    n_cmp++;
    if ({vld_cnt[0] == 0, dut_a.state_q == ST_IDLE} !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_mid_low_line: got %0d valid cycles state %0d want 0 and %0d",
               vld_cnt[0], dut_a.state_q, ST_IDLE);
    end
    rx[0] = 1'b1;
    repeat (50) @(negedge clk);
    send_bits(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
    repeat (50) @(negedge clk);
    n_cmp++;
    if ({cap_data[0], cap_flags[0]} !== {8'hA5, 3'b000}) begin
      n_bad++;
      $display("FAIL rst_mid_next: got data=%h flags=%b want a5 000", cap_data[0], cap_flags[0]);
    end
    n_cmp++;
    if (vld_cnt[0] !== 1) begin
      n_bad++;
      $display("FAIL rst_mid_next_cycles: got %0d want 1", vld_cnt[0]);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_false_start();
    test_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
